// File: rtl/pps_edge_qual.sv
// 1PPS front-end: synchronises the raw PPS level, finds rising edges, measures the
// interval between them and forwards only in-window edges, with lock/error/missing status.
module pps_edge_qual #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD      = 100_000_000,
    parameter int TOL         = 1000,
    parameter int LOCK_COUNT  = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic             q,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             err,
    output logic             missing
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LO_C  = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(PERIOD + TOL);

    localparam logic [1:0] ST_ACQ   = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("pps_edge_qual: SYNC_STAGES must be >= 2");
    end
    if (CNT_W < 63 && ((64'd1 << CNT_W) - 64'd1) < (longint'(PERIOD) + longint'(TOL) + 64'd1)) begin : g_cnt_w_check
        $error("pps_edge_qual: CNT_W too narrow for PERIOD+TOL+1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]          good_q, good_d;
    logic [1:0]             state_q, state_d;
    logic                   q_q, q_d;
    logic                   locked_q, locked_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   err_q, err_d;
    logic                   missing_q, missing_d;

    logic             e;
    logic             timeout;
    logic             in_window;
    logic [CNT_W-1:0] interval;
    logic [GW-1:0]    good_inc;

    assign sync_d[0] = d;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end

    assign prev_d    = sync_q[SYNC_STAGES-1];
    assign e         = sync_q[SYNC_STAGES-1] & ~prev_q;
    // cnt saturates at MAX_C, so the +1 can never overflow CNT_W
    assign interval  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign timeout   = (cnt_q == MAX_C);
    assign in_window = (interval >= LO_C) && (interval <= MAX_C);
    assign good_inc  = good_q + {{(GW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        q_d       = 1'b0;
        err_d     = 1'b0;
        missing_d = 1'b0;
        locked_d  = locked_q;
        period_d  = period_q;
        if (e) begin
            cnt_d = '0;
        end else if (timeout) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = interval;
        end

        case (state_q)
            ST_ACQ: begin
                if (e) begin
                    state_d = ST_TRACK;
                    good_d  = '0;
                end
            end
            ST_TRACK, ST_LOCK: begin
                // an edge coinciding with timeout is still an edge (it just lands out of window)
                if (e) begin
                    period_d = interval;
                    if (in_window) begin
                        q_d = 1'b1;
                        if (state_q == ST_TRACK) begin
                            good_d = good_inc;
                            if (good_inc == GW'(LOCK_COUNT)) begin
                                state_d  = ST_LOCK;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        err_d    = 1'b1;
                        good_d   = '0;
                        locked_d = 1'b0;
                        state_d  = ST_TRACK;
                    end
                end else if (timeout) begin
                    missing_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = '0;
                    state_d   = ST_ACQ;
                end
            end
            default: begin
                state_d  = ST_ACQ;
                good_d   = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            good_q    <= '0;
            state_q   <= ST_ACQ;
            q_q       <= 1'b0;
            locked_q  <= 1'b0;
            period_q  <= '0;
            err_q     <= 1'b0;
            missing_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            state_q   <= state_d;
            q_q       <= q_d;
            locked_q  <= locked_d;
            period_q  <= period_d;
            err_q     <= err_d;
            missing_q <= missing_d;
        end
    end

    assign q       = q_q;
    assign locked  = locked_q;
    assign period  = period_q;
    assign err     = err_q;
    assign missing = missing_q;

endmodule

// File: tb/tb_pps_edge_qual.sv
// Directed bench for pps_edge_qual with PERIOD=100, TOL=2, LOCK_COUNT=3, two sync stages.
module tb_pps_edge_qual;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          d = 1'b0;
    logic          q, locked, err, missing;
    logic [CW-1:0] period;

    int total = 0;
    int bad   = 0;

    pps_edge_qual #(
        .SYNC_STAGES(2),
        .PERIOD(100),
        .TOL(2),
        .LOCK_COUNT(3),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .d(d),
        .q(q),
        .locked(locked),
        .period(period),
        .err(err),
        .missing(missing)
    );

    always #5 clk = ~clk;

    // Drives a 1-cycle d pulse `gap` cycles after the previous one and samples outputs
    // 3 cycles after d rose; stray counts any q/err/missing seen where none is expected.
    task automatic send_edge(input int gap, output logic oq, output logic oe, output logic ol,
                             output logic [CW-1:0] op, output int stray);
        stray = 0;
        repeat (gap - 3) begin
            @(negedge clk);
            if (q || err || missing) stray++;
        end
        d = 1'b1;
        @(negedge clk);
        d = 1'b0;
        if (q || err || missing) stray++;
        @(negedge clk);
        if (q || err || missing) stray++;
        @(negedge clk);
        oq = q; oe = err; ol = locked; op = period;
        if (missing) stray++;
    endtask

    task automatic test_reset();
        #500;
        total++;
        if ({q, err, missing, locked, period} !== {4'b0000, {CW{1'b0}}}) begin
            bad++;
            $display("FAIL reset_state: got q=%b err=%b missing=%b locked=%b period=%0d, want all 0",
                     q, err, missing, locked, period);
        end else $display("reset_state ok");
        #501;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_acquire_lock();
        int       g [5] = '{10, 100, 100, 100, 100};
        bit [2:0] ex[5] = '{3'b000, 3'b100, 3'b100, 3'b101, 3'b101};
        int       ep[5] = '{0, 100, 100, 100, 100};
        logic oq, oe, ol; logic [CW-1:0] op; int st;
        for (int i = 0; i < 5; i++) begin
            send_edge(g[i], oq, oe, ol, op, st);
            total++;
            if ({oq, oe, ol, op} !== {ex[i], CW'(ep[i])} || st != 0) begin
                bad++;
                $display("FAIL acquire edge%0d: got q=%b err=%b locked=%b period=%0d stray=%0d, want q=%b err=%b locked=%b period=%0d stray=0",
                         i, oq, oe, ol, op, st, ex[i][2], ex[i][1], ex[i][0], ep[i]);
            end else $display("acquire edge%0d gap=%0d q=%b err=%b locked=%b period=%0d", i, g[i], oq, oe, ol, op);
        end
    endtask

    task automatic test_bad_interval();
        int       g [4] = '{97, 100, 100, 100};
        bit [2:0] ex[4] = '{3'b010, 3'b100, 3'b100, 3'b101};
        int       ep[4] = '{97, 100, 100, 100};
        logic oq, oe, ol; logic [CW-1:0] op; int st;
        for (int i = 0; i < 4; i++) begin
            send_edge(g[i], oq, oe, ol, op, st);
            total++;
            if ({oq, oe, ol, op} !== {ex[i], CW'(ep[i])} || st != 0) begin
                bad++;
                $display("FAIL bad_interval edge%0d: got q=%b err=%b locked=%b period=%0d stray=%0d, want q=%b err=%b locked=%b period=%0d stray=0",
                         i, oq, oe, ol, op, st, ex[i][2], ex[i][1], ex[i][0], ep[i]);
            end else $display("bad_interval edge%0d gap=%0d q=%b err=%b locked=%b period=%0d", i, g[i], oq, oe, ol, op);
        end
    endtask

    task automatic test_window_bounds();
        int       g [4] = '{98, 102, 103, 101};
        bit [2:0] ex[4] = '{3'b101, 3'b101, 3'b010, 3'b100};
        int       ep[4] = '{98, 102, 103, 101};
        logic oq, oe, ol; logic [CW-1:0] op; int st;
        for (int i = 0; i < 4; i++) begin
            send_edge(g[i], oq, oe, ol, op, st);
            total++;
            if ({oq, oe, ol, op} !== {ex[i], CW'(ep[i])} || st != 0) begin
                bad++;
                $display("FAIL window edge%0d: got q=%b err=%b locked=%b period=%0d stray=%0d, want q=%b err=%b locked=%b period=%0d stray=0",
                         i, oq, oe, ol, op, st, ex[i][2], ex[i][1], ex[i][0], ep[i]);
            end else $display("window edge%0d gap=%0d q=%b err=%b locked=%b period=%0d", i, g[i], oq, oe, ol, op);
        end
    endtask

    task automatic test_missing();
        int       g [4] = '{100, 100, 10, 100};
        bit [2:0] ex[4] = '{3'b100, 3'b101, 3'b000, 3'b100};
        logic oq, oe, ol; logic [CW-1:0] op; int st;
        int   miss_bad;
        logic lk;
        for (int i = 0; i < 2; i++) begin
            send_edge(g[i], oq, oe, ol, op, st);
            total++;
            if ({oq, oe, ol, op} !== {ex[i], CW'(100)} || st != 0) begin
                bad++;
                $display("FAIL missing_pre edge%0d: got q=%b err=%b locked=%b period=%0d stray=%0d, want q=%b err=%b locked=%b period=100 stray=0",
                         i, oq, oe, ol, op, st, ex[i][2], ex[i][1], ex[i][0]);
            end else $display("missing_pre edge%0d gap=%0d q=%b locked=%b", i, g[i], oq, ol);
        end
        // last q is visible now; missing must appear exactly 103 cycles later
        miss_bad = 0;
        lk = 1'b1;
        for (int i = 1; i <= 104; i++) begin
            @(negedge clk);
            if (missing !== (i == 103)) miss_bad++;
            if (q || err) miss_bad++;
            if (i == 103) lk = locked;
        end
        total++;
        if (miss_bad != 0 || lk !== 1'b0) begin
            bad++;
            $display("FAIL missing_pulse: got bad_cycles=%0d locked=%b, want bad_cycles=0 locked=0", miss_bad, lk);
        end else $display("missing_pulse seen once, locked dropped");
        for (int i = 2; i < 4; i++) begin
            send_edge(g[i], oq, oe, ol, op, st);
            total++;
            if ({oq, oe, ol, op} !== {ex[i], CW'(100)} || st != 0) begin
                bad++;
                $display("FAIL missing_post edge%0d: got q=%b err=%b locked=%b period=%0d stray=%0d, want q=%b err=%b locked=%b period=100 stray=0",
                         i, oq, oe, ol, op, st, ex[i][2], ex[i][1], ex[i][0]);
            end else $display("missing_post edge%0d gap=%0d q=%b locked=%b", i, g[i], oq, ol);
        end
    endtask

    task automatic test_hold_and_glitch();
        int       g [3] = '{10, 100, 50};
        bit [2:0] ex[3] = '{3'b000, 3'b100, 3'b010};
        int       ep[3] = '{100, 100, 50};
        logic oq, oe, ol; logic [CW-1:0] op; int st;
        int nq, ne, nm;
        repeat (97) @(negedge clk);
        d = 1'b1;
        nq = 0; ne = 0; nm = 0;
        // held level gives one q at interval 100, then times out while still high
        repeat (300) begin
            @(negedge clk);
            if (q === 1'b1) nq++;
            if (err === 1'b1) ne++;
            if (missing === 1'b1) nm++;
        end
        d = 1'b0;
        total++;
        if (nq != 1 || ne != 0 || nm != 1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL hold_high: got q=%0d err=%0d missing=%0d locked=%b, want q=1 err=0 missing=1 locked=0",
                     nq, ne, nm, locked);
        end else $display("hold_high q=%0d err=%0d missing=%0d", nq, ne, nm);
        for (int i = 0; i < 3; i++) begin
            send_edge(g[i], oq, oe, ol, op, st);
            total++;
            if ({oq, oe, ol, op} !== {ex[i], CW'(ep[i])} || st != 0) begin
                bad++;
                $display("FAIL glitch edge%0d: got q=%b err=%b locked=%b period=%0d stray=%0d, want q=%b err=%b locked=%b period=%0d stray=0",
                         i, oq, oe, ol, op, st, ex[i][2], ex[i][1], ex[i][0], ep[i]);
            end else $display("glitch edge%0d gap=%0d q=%b err=%b period=%0d", i, g[i], oq, oe, op);
        end
    endtask

    task automatic test_async_reset();
        int       g [5] = '{100, 100, 100, 10, 100};
        bit [2:0] ex[5] = '{3'b100, 3'b100, 3'b101, 3'b000, 3'b100};
        int       ep[5] = '{100, 100, 100, 0, 100};
        logic oq, oe, ol; logic [CW-1:0] op; int st;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                total++;
                if ({q, err, missing, locked, period} !== {4'b0000, {CW{1'b0}}}) begin
                    bad++;
                    $display("FAIL async_reset: got q=%b err=%b missing=%b locked=%b period=%0d, want all 0",
                             q, err, missing, locked, period);
                end else $display("async_reset cleared outputs");
                @(negedge clk);
                #3 rst_n = 1'b1;
            end
            send_edge(g[i], oq, oe, ol, op, st);
            total++;
            if ({oq, oe, ol, op} !== {ex[i], CW'(ep[i])} || st != 0) begin
                bad++;
                $display("FAIL reset_relock edge%0d: got q=%b err=%b locked=%b period=%0d stray=%0d, want q=%b err=%b locked=%b period=%0d stray=0",
                         i, oq, oe, ol, op, st, ex[i][2], ex[i][1], ex[i][0], ep[i]);
            end else $display("reset_relock edge%0d gap=%0d q=%b locked=%b period=%0d", i, g[i], oq, ol, op);
        end
    endtask

    initial begin
        test_reset();
        test_acquire_lock();
        test_bad_interval();
        test_window_bounds();
        test_missing();
        test_hold_and_glitch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
